// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: one shared memory port, FSM-sequenced datapath.
// Halts on illegal opcodes, misaligned load/store addresses and memory timeouts.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic [2:0]  state_out,
  output logic        halted
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg, ir_reg, a_reg, b_reg, target_reg, alu_reg, mdr_reg;
  logic [CW-1:0] wait_cnt_reg;
  logic [31:0]   rf [NUM_REGS];

  logic [5:0]    opcode, funct;
  logic [RW-1:0] rs_idx, rt_idx, rd_idx, rf_waddr;
  logic [31:0]   imm_sext, alu_result, rf_wdata;
  logic          is_rtype, is_addi, is_lw, is_sw, is_beq, is_j;
  logic          funct_ok, op_ok, wait_timeout, rf_we;
  logic          unused_bits;

  assign opcode   = ir_reg[31:26];
  assign funct    = ir_reg[5:0];
  assign rs_idx   = ir_reg[21 +: RW];
  assign rt_idx   = ir_reg[16 +: RW];
  assign rd_idx   = ir_reg[11 +: RW];
  assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);

  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);
  assign op_ok    = (is_rtype && funct_ok) || is_addi || is_lw || is_sw || is_beq || is_j;

  assign wait_timeout = (wait_cnt_reg == WAIT_LAST);

  // Same adder serves addi and the lw/sw effective address
  always_comb begin
    alu_result = a_reg + imm_sext;
    if (is_rtype) begin
      case (funct)
        FN_ADD:  alu_result = a_reg + b_reg;
        FN_SUB:  alu_result = a_reg - b_reg;
        FN_AND:  alu_result = a_reg & b_reg;
        FN_OR:   alu_result = a_reg | b_reg;
        FN_SLT:  alu_result = {31'b0, $signed(a_reg) < $signed(b_reg)};
        default: alu_result = '0;
      endcase
    end
  end

  assign rf_waddr = is_rtype ? rd_idx : rt_idx;
  assign rf_wdata = is_lw ? mdr_reg : alu_reg;
  assign rf_we    = (state_reg == S_WB) && (rf_waddr != '0);

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_reg;
        if (mem_ready)         state_next = S_DECODE;
        else if (wait_timeout) state_next = S_HALT;
      end
      S_DECODE: state_next = op_ok ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_rtype || is_addi)  state_next = S_WB;
        else if (is_lw || is_sw)  state_next = (alu_result[1:0] == 2'b00) ? S_MEM : S_HALT;
        else if (is_beq || is_j)  state_next = S_FETCH;
        else                      state_next = S_HALT;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        mem_addr  = alu_reg;
        mem_wdata = is_sw ? b_reg : '0;
        if (mem_ready)         state_next = is_lw ? S_WB : S_FETCH;
        else if (wait_timeout) state_next = S_HALT;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
    // Bus is quiet for the whole reset so an in-flight access is abandoned
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      target_reg   <= '0;
      alu_reg      <= '0;
      mdr_reg      <= '0;
      wait_cnt_reg <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      state_reg <= state_next;
      if (mem_req) wait_cnt_reg <= mem_ready ? '0 : wait_cnt_reg + CW'(1);
      if (state_reg == S_FETCH && mem_ready) begin
        ir_reg <= mem_rdata;
        pc_reg <= pc_reg + 32'd4;
      end
      if (state_reg == S_DECODE) begin
        a_reg      <= rf[rs_idx];
        b_reg      <= rf[rt_idx];
        target_reg <= pc_reg + {imm_sext[29:0], 2'b00};
      end
      if (state_reg == S_EXEC) begin
        alu_reg <= alu_result;
        if (is_beq && (a_reg == b_reg)) pc_reg <= target_reg;
        if (is_j) pc_reg <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
      end
      if (state_reg == S_MEM && mem_ready) mdr_reg <= mem_rdata;
      if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
  end

  assign pc_out      = pc_reg;
  assign state_out   = state_reg;
  assign halted      = (state_reg == S_HALT);
  assign unused_bits = ^{ir_reg, imm_sext};

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core with a wait-state-programmable memory model.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [2:0]  state_out;
  logic        halted;

  logic [31:0] tb_mem [0:255];
  int          wait_states = 0;
  bit          hold_low = 1'b0;
  int          stall_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  mips_multicycle_core dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_out(pc_out), .state_out(state_out), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory answers on the falling edge; the access completes at the next rising edge
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !hold_low) begin
        if (stall_cnt >= wait_states) begin
          mem_ready = 1'b1;
          mem_rdata = tb_mem[mem_addr[9:2]];
          if (mem_we) tb_mem[mem_addr[9:2]] = mem_wdata;
          stall_cnt = 0;
        end else begin
          mem_ready = 1'b0;
          stall_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
  endtask

  task automatic start_core();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_mem();
    wait_states = 0;
    tb_mem[0] = 32'h2001_0005;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc_out); end
    n_checks++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
    rst = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h expected 0", mem_addr); end
    tick();
    n_checks++; if (state_out !== 3'd1) begin n_fail++; $display("FAIL fetch_to_decode: got %0d expected 1", state_out); end
    n_checks++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL fetch_pc_inc: got %h expected 4", pc_out); end
    $display("test_reset done");
  endtask

  task automatic test_alu_program();
    int bad_req;
    clear_mem();
    wait_states = 0;
    tb_mem[0] = 32'h2001_0005;  // addi $1,$0,5
    tb_mem[1] = 32'h2002_0007;  // addi $2,$0,7
    tb_mem[2] = 32'h0022_1820;  // add  $3,$1,$2
    tb_mem[3] = 32'hAC03_0040;  // sw   $3,0x40($0)
    tb_mem[4] = 32'h1000_FFFF;  // beq  $0,$0,-1
    start_core();
    bad_req = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (mem_req && state_out != 3'd0) bad_req++;
    end
    n_checks++; if (bad_req !== 0) begin n_fail++; $display("FAIL req_outside_fetch: got %0d expected 0", bad_req); end
    n_checks++; if (pc_out !== 32'd12) begin n_fail++; $display("FAIL alu_prog_pc: got %h expected 0000000c", pc_out); end
    n_checks++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL alu_prog_state: got %0d expected 0", state_out); end
    repeat (8) tick();
    n_checks++; if (tb_mem[16] !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h expected 0000000c", tb_mem[16]); end
    $display("test_alu_program done");
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp_vals [5];
    clear_mem();
    wait_states = 1;
    tb_mem[0]  = 32'h2001_FFFD;  // addi $1,$0,-3
    tb_mem[1]  = 32'h2002_0005;  // addi $2,$0,5
    tb_mem[2]  = 32'h0022_1822;  // sub  $3,$1,$2
    tb_mem[3]  = 32'h0022_2024;  // and  $4,$1,$2
    tb_mem[4]  = 32'h0022_2825;  // or   $5,$1,$2
    tb_mem[5]  = 32'h0022_302A;  // slt  $6,$1,$2
    tb_mem[6]  = 32'h0041_382A;  // slt  $7,$2,$1
    tb_mem[7]  = 32'hAC03_0040;
    tb_mem[8]  = 32'hAC04_0044;
    tb_mem[9]  = 32'hAC05_0048;
    tb_mem[10] = 32'hAC06_004C;
    tb_mem[11] = 32'hAC07_0050;
    tb_mem[12] = 32'h1000_FFFF;
    for (int i = 16; i < 21; i++) tb_mem[i] = 32'hDEAD_BEEF;
    exp_vals[0] = 32'hFFFF_FFF8;
    exp_vals[1] = 32'h0000_0005;
    exp_vals[2] = 32'hFFFF_FFFD;
    exp_vals[3] = 32'h0000_0001;
    exp_vals[4] = 32'h0000_0000;
    start_core();
    repeat (80) tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (tb_mem[16 + i] !== exp_vals[i]) begin
        n_fail++;
        $display("FAIL alu_op%0d: got %h expected %h", i, tb_mem[16 + i], exp_vals[i]);
      end
    end
    $display("test_alu_ops done");
  endtask

  task automatic test_mem_stall();
    logic        prev_stall;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;
    clear_mem();
    wait_states = 2;
    tb_mem[0] = 32'h2003_000C;  // addi $3,$0,12
    tb_mem[1] = 32'hAC03_0010;  // sw   $3,0x10($0)
    tb_mem[2] = 32'h8C04_0010;  // lw   $4,0x10($0)
    tb_mem[3] = 32'h0800_0006;  // j    0x18
    tb_mem[6] = 32'hAC04_0020;  // sw   $4,0x20($0)
    tb_mem[7] = 32'h1000_FFFF;
    start_core();
    prev_stall = 1'b0;
    prev_addr = '0;
    prev_wdata = '0;
    prev_we = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (prev_stall) begin
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata) begin
          n_fail++;
          $display("FAIL stall_stable: got req=%b addr=%h we=%b wdata=%h expected req=1 addr=%h we=%b wdata=%h",
                   mem_req, mem_addr, mem_we, mem_wdata, prev_addr, prev_we, prev_wdata);
        end
      end
      prev_stall = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
    end
    n_checks++; if (tb_mem[4] !== 32'd12) begin n_fail++; $display("FAIL sw_stalled: got %h expected 0000000c", tb_mem[4]); end
    n_checks++; if (tb_mem[8] !== 32'd12) begin n_fail++; $display("FAIL lw_stalled: got %h expected 0000000c", tb_mem[8]); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL stall_no_halt: got %b expected 0", halted); end
    $display("test_mem_stall done");
  endtask

  task automatic test_branch();
    clear_mem();
    wait_states = 0;
    tb_mem[0] = 32'h2001_0003;  // addi $1,$0,3
    tb_mem[1] = 32'h2002_0004;  // addi $2,$0,4
    tb_mem[2] = 32'h1022_0005;  // beq  $1,$2,+5 (not taken)
    tb_mem[3] = 32'h1021_FFFF;  // beq  $1,$1,-1
    start_core();
    repeat (8) tick();
    n_checks++; if (pc_out !== 32'd8) begin n_fail++; $display("FAIL br_setup_pc: got %h expected 00000008", pc_out); end
    repeat (3) tick();
    n_checks++; if (pc_out !== 32'd12) begin n_fail++; $display("FAIL beq_not_taken: got %h expected 0000000c", pc_out); end
    tick();
    n_checks++; if (pc_out !== 32'd16) begin n_fail++; $display("FAIL beq_fetch_pc: got %h expected 00000010", pc_out); end
    repeat (2) tick();
    n_checks++; if (pc_out !== 32'd12 || state_out !== 3'd0) begin n_fail++; $display("FAIL beq_taken1: got pc=%h st=%0d expected pc=0000000c st=0", pc_out, state_out); end
    repeat (3) tick();
    n_checks++; if (pc_out !== 32'd12 || state_out !== 3'd0) begin n_fail++; $display("FAIL beq_taken2: got pc=%h st=%0d expected pc=0000000c st=0", pc_out, state_out); end
    $display("test_branch done");
  endtask

  task automatic test_halt();
    int bad_req;
    // Illegal opcode
    clear_mem();
    wait_states = 0;
    tb_mem[0] = 32'hFC00_0000;
    start_core();
    repeat (2) tick();
    n_checks++; if (state_out !== 3'd7) begin n_fail++; $display("FAIL illegal_state: got %0d expected 7", state_out); end
    n_checks++; if (halted !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL illegal_halt: got halted=%b req=%b expected 1/0", halted, mem_req); end
    repeat (5) tick();
    n_checks++; if (pc_out !== 32'd4) begin n_fail++; $display("FAIL halt_pc_frozen: got %h expected 00000004", pc_out); end
    rst = 1'b1;
    tick();
    n_checks++; if (pc_out !== 32'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got pc=%h halted=%b expected 0/0", pc_out, halted); end
    // Misaligned load
    tb_mem[0] = 32'h8C04_0011;  // lw $4,0x11($0)
    start_core();
    bad_req = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (mem_req && state_out != 3'd0) bad_req++;
    end
    n_checks++; if (state_out !== 3'd7 || halted !== 1'b1) begin n_fail++; $display("FAIL misalign_halt: got st=%0d halted=%b expected 7/1", state_out, halted); end
    n_checks++; if (bad_req !== 0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL misalign_req: got %0d stray reqs, req=%b expected 0/0", bad_req, mem_req); end
    // Bus timeout: MAX_WAIT stall cycles on the first fetch
    hold_low = 1'b1;
    start_core();
    repeat (254) tick();
    n_checks++; if (state_out !== 3'd0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got st=%0d req=%b expected 0/1", state_out, mem_req); end
    tick();
    n_checks++; if (state_out !== 3'd7 || mem_req !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL timeout_halt: got st=%0d req=%b halted=%b expected 7/0/1", state_out, mem_req, halted); end
    hold_low = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++; if (pc_out !== 32'd0 || halted !== 1'b0 || state_out !== 3'd0) begin n_fail++; $display("FAIL timeout_reset: got pc=%h halted=%b st=%0d expected 0/0/0", pc_out, halted, state_out); end
    $display("test_halt done");
  endtask

  task automatic test_zero_reg();
    clear_mem();
    wait_states = 0;
    tb_mem[0] = 32'h2000_0009;  // addi $0,$0,9
    tb_mem[1] = 32'h0000_2820;  // add  $5,$0,$0
    tb_mem[2] = 32'hAC05_0040;  // sw   $5,0x40($0)
    tb_mem[3] = 32'hAC00_0044;  // sw   $0,0x44($0)
    tb_mem[4] = 32'h1000_FFFF;
    tb_mem[16] = 32'hDEAD_BEEF;
    tb_mem[17] = 32'hDEAD_BEEF;
    start_core();
    repeat (24) tick();
    n_checks++; if (tb_mem[16] !== 32'h0) begin n_fail++; $display("FAIL zero_reg_add: got %h expected 0", tb_mem[16]); end
    n_checks++; if (tb_mem[17] !== 32'h0) begin n_fail++; $display("FAIL zero_reg_read: got %h expected 0", tb_mem[17]); end
    $display("test_zero_reg done");
  endtask

  task automatic test_overflow();
    clear_mem();
    wait_states = 0;
    tb_mem[0] = 32'h8C01_0040;  // lw   $1,0x40($0)
    tb_mem[1] = 32'h2002_0001;  // addi $2,$0,1
    tb_mem[2] = 32'h0022_1820;  // add  $3,$1,$2
    tb_mem[3] = 32'hAC03_0044;  // sw   $3,0x44($0)
    tb_mem[4] = 32'h1000_FFFF;
    tb_mem[16] = 32'h7FFF_FFFF;
    start_core();
    repeat (5) tick();
    n_checks++; if (pc_out !== 32'd4 || state_out !== 3'd0) begin n_fail++; $display("FAIL lw_latency: got pc=%h st=%0d expected 00000004/0", pc_out, state_out); end
    repeat (12) tick();
    n_checks++; if (pc_out !== 32'd16) begin n_fail++; $display("FAIL ovf_pc: got %h expected 00000010", pc_out); end
    n_checks++; if (tb_mem[17] !== 32'h8000_0000) begin n_fail++; $display("FAIL add_overflow: got %h expected 80000000", tb_mem[17]); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL ovf_no_halt: got %b expected 0", halted); end
    $display("test_overflow done");
  endtask

  task automatic test_abort_reset();
    bit reached;
    clear_mem();
    wait_states = 3;
    tb_mem[0] = 32'h2001_0005;  // addi $1,$0,5
    tb_mem[1] = 32'hAC01_0040;  // sw   $1,0x40($0)
    tb_mem[2] = 32'h1000_FFFF;
    tb_mem[16] = 32'hAAAA_5555;
    start_core();
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      tick();
      if (state_out == 3'd3) reached = 1'b1;
    end
    n_checks++; if (reached !== 1'b1) begin n_fail++; $display("FAIL abort_reach_mem: got %b expected 1", reached); end
    rst = 1'b1;
    #1;
    tick();
    n_checks++; if (mem_req !== 1'b0 || state_out !== 3'd0) begin n_fail++; $display("FAIL abort_req: got req=%b st=%0d expected 0/0", mem_req, state_out); end
    rst = 1'b0;
    n_checks++; if (tb_mem[16] !== 32'hAAAA_5555) begin n_fail++; $display("FAIL abort_no_write: got %h expected aaaa5555", tb_mem[16]); end
    repeat (3) tick();
    $display("test_abort_reset done");
  endtask

  initial begin
    test_reset();
    test_alu_program();
    test_alu_ops();
    test_mem_stall();
    test_branch();
    test_halt();
    test_zero_reg();
    test_overflow();
    test_abort_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NUM_REGS, default 32: register-file depth; legal values are powers of two from 8 to 32; register indices wrap modulo NUM_REGS.
REQ-003 Parameter MAX_WAIT, default 255: memory stall-cycle limit before the core reports a bus error.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port mem_req, output, 1: memory access request.
REQ-007 Port mem_we, output, 1: 1 = write, 0 = read.
REQ-008 Port mem_addr, output, 32: byte address, word aligned.
REQ-009 Port mem_wdata, output, 32: store data.
REQ-010 Port mem_rdata, input, 32: read data, valid while mem_ready=1.
REQ-011 Port mem_ready, input, 1: access completes at the edge where mem_req=1 and mem_ready=1.
REQ-012 Port pc_out, output, 32: current architectural PC.
REQ-013 Port state_out, output, 3: FSM state encoding.
REQ-014 Port halted, output, 1: core stopped (illegal opcode, misaligned access, or bus timeout).

Function
REQ-015 States are FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-016 FETCH drives mem_req=1, mem_we=0 and mem_addr=PC, and holds them until mem_ready; on completion it latches IR, sets PC=PC+4 and goes to DECODE.
REQ-017 DECODE reads rs and rt into A/B, computes branch target = PC + (sext(imm16)<<2), and goes to EXEC; an unsupported opcode goes to HALT.
REQ-018 Supported instructions: R-type add, sub, and, or, slt (funct 0x20, 0x22, 0x24, 0x25, 0x2A); addi (0x08); lw (0x23); sw (0x2B); beq (0x04); j (0x02).
REQ-019 An R-type instruction with an unsupported funct goes to HALT from DECODE.
REQ-020 EXEC for R-type and addi computes the ALU result and goes to WB.
REQ-021 EXEC for lw and sw computes address = A + sext(imm16) and goes to MEM.
REQ-022 EXEC for beq sets PC=target if A==B and goes to FETCH.
REQ-023 EXEC for j sets PC={PC[31:28], imm26, 2'b00} and goes to FETCH.
REQ-024 MEM for lw reads and latches mem_rdata, then goes to WB.
REQ-025 MEM for sw writes B and goes to FETCH.
REQ-026 WB writes rd (R-type), or rt (addi, lw), then goes to FETCH.
REQ-027 Minimum latency with zero wait states: beq/j 3 cycles; R-type, addi and sw 4 cycles; lw 5 cycles.
REQ-028 Arithmetic is 32-bit two's-complement; overflow wraps and is not trapped; slt is a signed compare producing 1 or 0.
REQ-029 Register 0 reads 0 always; writes to it are discarded.
REQ-030 Outside FETCH and MEM, mem_req=0 and mem_we=0.
REQ-031 mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_ready=0.
REQ-032 A load or store address with addr[1:0]!=0 goes to HALT without issuing mem_req.
REQ-033 If MAX_WAIT consecutive stall cycles elapse without mem_ready, the core goes to HALT and drops mem_req.
REQ-034 mem_ready while mem_req=0 is ignored.
REQ-035 HALT holds halted=1, mem_req=0 and PC frozen until rst.
REQ-036 PC wraps 0xFFFF_FFFC -> 0x0000_0000.

Reset
REQ-037 Reset sets PC=RESET_PC, state=FETCH, all registers 0, IR 0, wait counter 0, halted=0, mem_req=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-038 rst asserted mid-access aborts the access: mem_req=0 on the following cycle and no register write occurs.
REQ-039 The first mem_req after rst deasserts appears in the first cycle rst is low.

Verification
REQ-040 Zero-wait memory, program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> $3=12 after 12 cycles, with mem_req seen only in FETCH.
REQ-041 sw $3,0x10($0) then lw $4,0x10($0) with 2 wait states per access -> memory word 0x10=12 and $4=12; address and data held stable during the stalls.
REQ-042 beq $1,$1,-1 -> PC returns to the same beq every 3 cycles; beq $1,$2 with unequal values -> PC+4.
REQ-043 Opcode 0x3F, lw from address 0x11, or mem_ready held low for MAX_WAIT cycles -> state=HALT, halted=1, mem_req=0; pulsing rst -> PC=RESET_PC and halted=0.
REQ-044 addi $0,$0,9 then add $5,$0,$0 -> $5=0.
REQ-045 add with operands 0x7FFF_FFFF and 1 -> result 0x8000_0000 with no halt.
